inc_conditioner: RTL

- Upstream input stage for the up/down counter: turns a raw, bouncy, asynchronous push-button into clean single-cycle increment pulses on the counter's `inc` input.
- Synchronises the button, debounces it and detects the press edge.
- Optionally auto-repeats while the button is held, so the counter steps continuously.
- Sits between the top-level input pin and counter.inc; all outputs are registered in the clk domain.

---
 rtl/inc_cond_pkg.sv | 14 +
 rtl/sync_debounce.sv | 50 +++++
 rtl/inc_conditioner.sv | 90 +++++++++
 3 files changed

// File: rtl/inc_cond_pkg.sv
// Shared definitions for the increment-pulse conditioner: repeat FSM state
// encoding and a counter-width helper.
package inc_cond_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    // Bits needed for a counter that runs 0 .. n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Button synchroniser and debouncer. level/rise present the debounced level and
// its rising strobe as they will be after the next edge, so a consumer can
// register them in step with its own state.
module sync_debounce
    import inc_cond_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CNT      = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int DB_W = cnt_w(DB_CNT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DB_W-1:0]        db_cnt;
    logic                   level_q;
    logic                   s;
    logic                   flip;

    assign s    = sync_q[SYNC_STAGES-1];
    assign flip = (s != level_q) && (db_cnt == DB_W'(DB_CNT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            db_cnt  <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            // Any agreeing sample restarts the run of differing samples.
            if ((s == level_q) || flip) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
            if (flip) begin
                level_q <= s;
            end
        end
    end

    assign level = level_q ^ flip;
    assign rise  = flip & ~level_q;

endmodule

// File: rtl/inc_conditioner.sv
// Push-button to counter.inc conditioner: debounced press pulse plus optional
// auto-repeat (first repeat after REPEAT_DELAY, then every REPEAT_RATE).
module inc_conditioner
    import inc_cond_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int DB_CNT       = 16,
    parameter int REPEAT_DELAY = 64,
    parameter int REPEAT_RATE  = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    input  logic repeat_en,
    output logic inc_pulse,
    output logic btn_level,
    output logic repeating
);

    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = cnt_w(REP_MAX);

    logic             level_nxt;
    logic             press;
    logic             release_ev;
    logic             term;
    logic [1:0]       state;
    logic [REP_W-1:0] rep_cnt;

    sync_debounce #(
        .SYNC_STAGES(SYNC_STAGES),
        .DB_CNT     (DB_CNT)
    ) u_sync_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (btn_in),
        .level(level_nxt),
        .rise (press)
    );

    assign release_ev = btn_level & ~level_nxt;
    assign term = ((state == ST_DELAY)  && (rep_cnt == REP_W'(REPEAT_DELAY - 1))) ||
                  ((state == ST_REPEAT) && (rep_cnt == REP_W'(REPEAT_RATE - 1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rep_cnt   <= '0;
            inc_pulse <= 1'b0;
            btn_level <= 1'b0;
            repeating <= 1'b0;
        end else begin
            btn_level <= level_nxt;
            inc_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    rep_cnt   <= '0;
                    repeating <= 1'b0;
                    if (press) begin
                        inc_pulse <= 1'b1;
                        if (repeat_en) begin
                            state <= ST_DELAY;
                        end
                    end
                end
                ST_DELAY, ST_REPEAT: begin
                    // Release or disable wins over a coincident terminal count.
                    if (release_ev || !repeat_en) begin
                        state     <= ST_IDLE;
                        rep_cnt   <= '0;
                        repeating <= 1'b0;
                    end else if (term) begin
                        inc_pulse <= 1'b1;
                        state     <= ST_REPEAT;
                        rep_cnt   <= '0;
                        repeating <= 1'b1;
                    end else begin
                        rep_cnt <= rep_cnt + REP_W'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    rep_cnt   <= '0;
                    repeating <= 1'b0;
                end
            endcase
        end
    end

endmodule
